// File: rtl/div_pkg.sv
// Shared execute-pipe types and constants for the iterative divider.
package div_pkg;

  typedef logic [63:0] u64;
  typedef logic [64:0] u65;

  localparam int unsigned DIV_ITERS = 64;

  typedef enum logic {IDLE, BUSY} div_state_t;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negation of two 64-bit values; used for abs() on
// operands and for applying the result signs.
module div_sign_fix
  import div_pkg::*;
(
  input  logic neg_x,
  input  u64   x,
  input  logic neg_y,
  input  u64   y,
  output u64   x_fixed,
  output u64   y_fixed
);

  assign x_fixed = neg_x ? (~x + 64'd1) : x;
  assign y_fixed = neg_y ? (~y + 64'd1) : y;

endmodule

// File: rtl/div.sv
// Iterative 64-bit restoring divider (UDIV/SDIV), one quotient bit per cycle.
// Optional build macro DIV_ZERO_FAST_EN: divide by zero completes in the accepting cycle.
module div
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  input  logic        is_signed,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        done,
  output logic [63:0] q,
  output logic [63:0] r
);

  div_state_t state_q, state_d;
  logic [6:0] count_q, count_d;
  u65         rem_q, rem_d;
  u64         quo_q, quo_d;
  u64         dvs_q, dvs_d;
  logic       neg_q_q, neg_q_d;
  logic       neg_r_q, neg_r_d;
  logic       b_zero_q, b_zero_d;
  u64         q_out_q, q_out_d;
  u64         r_out_q, r_out_d;

  logic fast_zero;
  u64   a_mag, b_mag;
  u64   fix_q, fix_r;
  u65   shifted, trial, step_rem;
  u64   step_quo;

`ifdef DIV_ZERO_FAST_EN
  assign fast_zero = (b == '0);
`else
  assign fast_zero = 1'b0;
`endif

  div_sign_fix u_abs (
    .neg_x   (is_signed & a[63]),
    .x       (a),
    .neg_y   (is_signed & b[63]),
    .y       (b),
    .x_fixed (a_mag),
    .y_fixed (b_mag)
  );

  // One restoring step: the borrow out of the 65-bit subtraction decides the quotient bit.
  always_comb begin
    shifted  = (rem_q << 1) | {64'd0, quo_q[63]};
    trial    = shifted - {1'b0, dvs_q};
    step_rem = trial[64] ? shifted : trial;
    step_quo = {quo_q[62:0], ~trial[64]};
  end

  div_sign_fix u_res (
    .neg_x   (neg_q_q),
    .x       (step_quo),
    .neg_y   (neg_r_q),
    .y       (step_rem[63:0]),
    .x_fixed (fix_q),
    .y_fixed (fix_r)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    b_zero_d = b_zero_q;
    q_out_d  = q_out_q;
    r_out_d  = r_out_q;
    q        = q_out_q;
    r        = r_out_q;

    unique case (state_q)
      IDLE: begin
        if (valid && fast_zero) begin
          q_out_d = '0;
          r_out_d = a;
          q       = '0;
          r       = a;
        end else if (valid) begin
          state_d  = BUSY;
          count_d  = 7'(DIV_ITERS);
          rem_d    = '0;
          quo_d    = a_mag;
          dvs_d    = b_mag;
          neg_q_d  = is_signed & (a[63] ^ b[63]);
          neg_r_d  = is_signed & a[63];
          b_zero_d = (b == '0);
        end
      end
      BUSY: begin
        rem_d   = step_rem;
        quo_d   = step_quo;
        count_d = count_q - 7'd1;
        if (count_q == 7'd1) begin
          state_d = IDLE;
          // A zero divisor leaves quo all-ones; the remainder already equals the dividend.
          q_out_d = b_zero_q ? '0 : fix_q;
          r_out_d = fix_r;
          q       = q_out_d;
          r       = r_out_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign done = (state_d == IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      count_q  <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      b_zero_q <= 1'b0;
      q_out_q  <= '0;
      r_out_q  <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      b_zero_q <= b_zero_d;
      q_out_q  <= q_out_d;
      r_out_q  <= r_out_d;
    end
  end

endmodule
